// File: rtl/vga_reg_bank.sv
// vga_reg_bank: double-buffered register bank read by the VGA pointer block.
// Writes land in a pending bank; the pending bank is copied to the active bank
// on a frame boundary (unless the host holds WrLock), so a frame never shows a
// half-updated time. Values are stored as plain binary.
module vga_reg_bank #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int SEC_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WrStrobe,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              WrLock,
    input  logic              FrameStart,
    input  logic [ADDR_W-1:0] MemAddrIN,
    output logic [DATA_W-1:0] MemDataIN,
    output logic              WrAck,
    output logic              WrError,
    output logic              Dirty
);

    localparam int NREG = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] A_SEG_RELOJ  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_MIN_RELOJ  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_HOR_RELOJ  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_DAY        = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_MONTH      = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_YEAR       = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_SEG_CRONO  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_MIN_CRONO  = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_HOR_CRONO  = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] A_RING_CRONO = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] A_ACT_CRONO  = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] A_CURSOR     = ADDR_W'(12);

    // True when the address selects one of the mapped registers (1..12).
    function automatic logic addr_in_map(input logic [ADDR_W-1:0] addr);
        return (addr >= A_SEG_RELOJ) && (addr <= A_CURSOR);
    endfunction

    // True when the address is mapped and the value lies in that register's range.
    function automatic logic wr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
        logic ok;
        case (addr)
            A_SEG_RELOJ, A_MIN_RELOJ,
            A_SEG_CRONO, A_MIN_CRONO:   ok = (data <= DATA_W'(SEC_MAX));
            A_HOR_RELOJ, A_HOR_CRONO:   ok = (data <= DATA_W'(HOUR_MAX));
            A_DAY:                      ok = (data >= DATA_W'(1)) && (data <= DATA_W'(31));
            A_MONTH:                    ok = (data >= DATA_W'(1)) && (data <= DATA_W'(12));
            A_YEAR:                     ok = (data <= DATA_W'(99));
            // Flags keep bit0 only; any upper bit set is a malformed write.
            A_RING_CRONO, A_ACT_CRONO:  ok = (data <= DATA_W'(1));
            A_CURSOR:                   ok = (data <= DATA_W'(9));
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Reset value of a register slot: day and month start at 1, all else 0.
    function automatic logic [DATA_W-1:0] reset_value(input int idx);
        logic [DATA_W-1:0] v;
        if ((idx == int'(A_DAY)) || (idx == int'(A_MONTH))) begin
            v = DATA_W'(1);
        end else begin
            v = {DATA_W{1'b0}};
        end
        return v;
    endfunction

    // Slots 0 and 13..15 are never written, so they hold their reset zero and
    // synthesis trims them; indexing by the raw address keeps the muxes simple.
    logic [DATA_W-1:0] pend_q [NREG];
    logic [DATA_W-1:0] pend_d [NREG];
    logic [DATA_W-1:0] act_q  [NREG];
    logic [DATA_W-1:0] act_d  [NREG];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              dirty_q, dirty_d;
    logic              commit_s;
    logic              wr_ok_s;

    // Next-state: write acceptance, commit copy, dirty tracking and read mux.
    always_comb begin
        pend_d    = pend_q;
        act_d     = act_q;
        rd_data_d = {DATA_W{1'b0}};
        commit_s  = FrameStart & ~WrLock;
        wr_ok_s   = WrStrobe & wr_in_range(WrAddr, WrData);
        wr_ack_d  = wr_ok_s;
        wr_err_d  = WrStrobe & ~wr_ok_s;

        // The commit copies pending as it was before any same-cycle write.
        if (commit_s) begin
            act_d = pend_q;
        end else begin
            act_d = act_q;
        end

        if (wr_ok_s) begin
            pend_d[WrAddr] = WrData;
        end else begin
            pend_d[WrAddr] = pend_q[WrAddr];
        end

        // A write in the commit cycle is still uncommitted, so it wins.
        if (wr_ok_s) begin
            dirty_d = 1'b1;
        end else if (commit_s) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end

        if (addr_in_map(MemAddrIN)) begin
            rd_data_d = act_q[MemAddrIN];
        end else begin
            rd_data_d = {DATA_W{1'b0}};
        end
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= reset_value(i);
                act_q[i]  <= reset_value(i);
            end
            rd_data_q <= {DATA_W{1'b0}};
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            act_q     <= act_d;
            rd_data_q <= rd_data_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
            dirty_q   <= dirty_d;
        end
    end

    assign MemDataIN = rd_data_q;
    assign WrAck     = wr_ack_q;
    assign WrError   = wr_err_q;
    assign Dirty     = dirty_q;

endmodule

// File: tb/tb_vga_reg_bank.sv
// Scoreboard bench for vga_reg_bank: a driver applies directed and random
// cycles, a bank-level model predicts each cycle's outputs into a queue, and
// a monitor pops and compares after every clock edge.
module tb_vga_reg_bank;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       WrStrobe;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       WrLock;
    logic       FrameStart;
    logic [3:0] MemAddrIN;
    logic [7:0] MemDataIN;
    logic       WrAck;
    logic       WrError;
    logic       Dirty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rd;
        logic       ack;
        logic       err;
        logic       dirty;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model: two banks, a dirty flag, and per-address legal ranges.
    int pend_m [16];
    int act_m  [16];
    int lo_m   [16];
    int hi_m   [16];
    bit dirty_m;

    vga_reg_bank dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .WrStrobe  (WrStrobe),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .WrLock    (WrLock),
        .FrameStart(FrameStart),
        .MemAddrIN (MemAddrIN),
        .MemDataIN (MemDataIN),
        .WrAck     (WrAck),
        .WrError   (WrError),
        .Dirty     (Dirty)
    );

    // 10-unit clock.
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            pend_m[i] = (i == 4 || i == 5) ? 1 : 0;
            act_m[i]  = pend_m[i];
        end
        dirty_m = 1'b0;
    endtask

    // Apply one cycle of stimulus, predict the outputs after the edge, push them.
    task automatic drive(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic lk, input logic fs, input logic [3:0] ra);
        exp_t e;
        bit   ok;
        WrStrobe   = w;
        WrAddr     = a;
        WrData     = d;
        WrLock     = lk;
        FrameStart = fs;
        MemAddrIN  = ra;
        ok      = (int'(d) >= lo_m[a]) && (int'(d) <= hi_m[a]);
        e.rd    = 8'(act_m[ra]);
        e.ack   = w && ok;
        e.err   = w && !ok;
        if (fs && !lk) begin
            act_m   = pend_m;
            dirty_m = 1'b0;
        end
        if (w && ok) begin
            pend_m[a] = int'(d);
            dirty_m   = 1'b1;
        end
        e.dirty = dirty_m;
        sb_q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_read(input logic [3:0] ra);
        drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, ra);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"},    int'(MemDataIN), 0);
        check({tag, "_ack"},   int'(WrAck), 0);
        check({tag, "_err"},   int'(WrError), 0);
        check({tag, "_dirty"}, int'(Dirty), 0);
    endtask

    // Monitor: after every edge the DUT presents a new registered output set.
    always @(posedge CLK) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("rd_data", int'(MemDataIN), int'(mon_e.rd));
            check("wr_ack",  int'(WrAck),     int'(mon_e.ack));
            check("wr_err",  int'(WrError),   int'(mon_e.err));
            check("dirty",   int'(Dirty),     int'(mon_e.dirty));
        end
    end

    initial begin
        logic [3:0] ra;
        logic [3:0] a;
        logic [7:0] d;

        // Legal value ranges; unmapped addresses get an empty range.
        for (int i = 0; i < 16; i++) begin
            lo_m[i] = 1;
            hi_m[i] = 0;
        end
        lo_m[1] = 0;  hi_m[1] = 59;
        lo_m[2] = 0;  hi_m[2] = 59;
        lo_m[3] = 0;  hi_m[3] = 23;
        lo_m[4] = 1;  hi_m[4] = 31;
        lo_m[5] = 1;  hi_m[5] = 12;
        lo_m[6] = 0;  hi_m[6] = 99;
        lo_m[7] = 0;  hi_m[7] = 59;
        lo_m[8] = 0;  hi_m[8] = 59;
        lo_m[9] = 0;  hi_m[9] = 23;
        lo_m[10] = 0; hi_m[10] = 1;
        lo_m[11] = 0; hi_m[11] = 1;
        lo_m[12] = 0; hi_m[12] = 9;
        model_reset();

        RESET_N = 1'b0; WrStrobe = 1'b0; WrAddr = 4'd0; WrData = 8'd0;
        WrLock = 1'b0; FrameStart = 1'b0; MemAddrIN = 4'd0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #2;

        // Reset contents: day/month read 1, seconds 0, unmapped 0.
        idle_read(4'd4);
        idle_read(4'd5);
        idle_read(4'd1);
        idle_read(4'd0);

        // Write then commit.
        drive(1'b1, 4'd1, 8'd45, 1'b0, 1'b0, 4'd1);
        idle_read(4'd1);
        drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'd1);
        idle_read(4'd1);

        // Rejected writes, including the range edges.
        drive(1'b1, 4'd3,  8'd24,  1'b0, 1'b0, 4'd3);
        drive(1'b1, 4'd5,  8'd0,   1'b0, 1'b0, 4'd5);
        drive(1'b1, 4'd13, 8'd5,   1'b0, 1'b0, 4'd13);
        drive(1'b1, 4'd10, 8'h02,  1'b0, 1'b0, 4'd10);
        drive(1'b1, 4'd0,  8'd0,   1'b0, 1'b0, 4'd0);
        drive(1'b1, 4'd4,  8'd32,  1'b0, 1'b0, 4'd4);
        drive(1'b1, 4'd3,  8'd23,  1'b0, 1'b0, 4'd3);
        drive(1'b1, 4'd10, 8'h01,  1'b0, 1'b1, 4'd10);
        idle_read(4'd10);
        idle_read(4'd3);

        // WrLock defers the commit until a later unlocked FrameStart.
        drive(1'b1, 4'd2, 8'd30, 1'b1, 1'b0, 4'd2);
        drive(1'b0, 4'd0, 8'd0,  1'b1, 1'b1, 4'd2);
        drive(1'b0, 4'd0, 8'd0,  1'b0, 1'b0, 4'd2);
        drive(1'b0, 4'd0, 8'd0,  1'b0, 1'b1, 4'd2);
        idle_read(4'd2);

        // Write in the commit cycle stays pending.
        drive(1'b1, 4'd6, 8'd17, 1'b0, 1'b1, 4'd6);
        idle_read(4'd6);
        drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 4'd6);
        idle_read(4'd6);

        // Back-to-back writes, then commit and read back.
        drive(1'b1, 4'd12, 8'd9,  1'b0, 1'b0, 4'd12);
        drive(1'b1, 4'd7,  8'd59, 1'b0, 1'b0, 4'd7);
        drive(1'b1, 4'd11, 8'd1,  1'b0, 1'b1, 4'd12);
        idle_read(4'd12);
        idle_read(4'd11);

        // Mid-frame reset wipes both banks immediately.
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge CLK);
        #1;
        check_reset_outputs("midreset_hold");
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #2;
        idle_read(4'd12);
        idle_read(4'd4);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                d = 8'($urandom);
            end else begin
                d = 8'($urandom_range(0, (hi_m[a] > 0 ? hi_m[a] : 0) + 2));
            end
            ra = 4'($urandom_range(0, 15));
            drive(1'($urandom), a, d, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ra);
        end

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) begin
            @(posedge CLK);
            #2;
        end
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
